// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID register file: word map, CONTROL bit
// positions and uptime counter width.
package sysid_pkg;

  localparam int unsigned ADDR_SYSID     = 0;
  localparam int unsigned ADDR_TIMESTAMP = 1;
  localparam int unsigned ADDR_VERSION   = 2;
  localparam int unsigned ADDR_SCRATCH   = 3;
  localparam int unsigned ADDR_UPTIME_LO = 4;
  localparam int unsigned ADDR_UPTIME_HI = 5;
  localparam int unsigned ADDR_CONTROL   = 6;
  localparam int unsigned ADDR_INFO      = 7;
  localparam int unsigned ADDR_USER0     = 8;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  localparam int unsigned UPTIME_W = 64;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime counter with clear, enable and a high-word
// snapshot taken whenever the low word is read.
module sysid_uptime_counter
  import sysid_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear_i,
  input  logic                enable_i,
  input  logic                capture_i,
  output logic [UPTIME_W-1:0] count_o,
  output logic [31:0]         hi_shadow_o
);

  logic [UPTIME_W-1:0] count_q, count_d;
  logic [31:0]         hi_q, hi_d;

  // Clear wins over increment; natural overflow gives the wrap to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + UPTIME_W'(1);
    end
    hi_d = hi_q;
    if (capture_i) begin
      hi_d = count_q[UPTIME_W-1:32];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
      hi_q    <= '0;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
    end
  end

  assign count_o     = count_q;
  assign hi_shadow_o = hi_q;

endmodule

// File: rtl/sysid_regfile.sv
// System-ID slave: fixed identity words, scratch, control, uptime snapshot
// and sampled user status words, all read with a fixed one-cycle latency.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID  = 32'h0400_0000,
  parameter logic [31:0] TIMESTAMP  = 32'd1415959147,
  parameter logic [31:0] VERSION    = 32'h0001_0000,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned NUM_USER   = 4
) (
  input  logic                                          clock,
  input  logic                                          reset_n,
  input  logic [ADDR_WIDTH-1:0]                         address,
  input  logic                                          read,
  input  logic                                          write,
  input  logic [31:0]                                   writedata,
  output logic [31:0]                                   readdata,
  output logic                                          readdatavalid,
  input  logic [32*((NUM_USER > 0) ? NUM_USER : 1)-1:0] user_info,
  output logic                                          uptime_frozen
);

  localparam int unsigned NU_SAFE = (NUM_USER > 0) ? NUM_USER : 1;

  if (ADDR_USER0 + NUM_USER > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("sysid_regfile: 8+NUM_USER exceeds the address space");
  end

  logic [31:0]         user_words [NU_SAFE];
  logic [31:0]         rd_word;
  logic [31:0]         readdata_q, readdata_d;
  logic                rvalid_q, rvalid_d;
  logic [31:0]         scratch_q, scratch_d;
  logic                freeze_q, freeze_d;
  logic                wr_en, clear, capture;
  logic [UPTIME_W-1:0] uptime;
  logic [31:0]         hi_shadow;

  for (genvar gi = 0; gi < NU_SAFE; gi++) begin : g_user
    assign user_words[gi] = user_info[32*gi +: 32];
  end

  // A simultaneous read takes the bus cycle, so the write is dropped.
  assign wr_en   = write && !read;
  assign clear   = wr_en && (address == ADDR_WIDTH'(ADDR_CONTROL)) && writedata[CTRL_CLEAR];
  assign capture = read && (address == ADDR_WIDTH'(ADDR_UPTIME_LO));

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_WIDTH'(ADDR_SYSID):     rd_word = SYSTEM_ID;
      ADDR_WIDTH'(ADDR_TIMESTAMP): rd_word = TIMESTAMP;
      ADDR_WIDTH'(ADDR_VERSION):   rd_word = VERSION;
      ADDR_WIDTH'(ADDR_SCRATCH):   rd_word = scratch_q;
      ADDR_WIDTH'(ADDR_UPTIME_LO): rd_word = uptime[31:0];
      ADDR_WIDTH'(ADDR_UPTIME_HI): rd_word = hi_shadow;
      ADDR_WIDTH'(ADDR_CONTROL):   rd_word = {30'd0, freeze_q, 1'b0};
      ADDR_WIDTH'(ADDR_INFO):      rd_word = {16'd0, 8'(ADDR_WIDTH), 8'(NUM_USER)};
      default: begin
        for (int k = 0; k < int'(NUM_USER); k++) begin
          if (address == ADDR_WIDTH'(int'(ADDR_USER0) + k)) begin
            rd_word = user_words[k];
          end
        end
      end
    endcase
  end

  always_comb begin
    rvalid_d   = read;
    readdata_d = read ? rd_word : readdata_q;
    scratch_d  = scratch_q;
    freeze_d   = freeze_q;
    if (wr_en && (address == ADDR_WIDTH'(ADDR_SCRATCH))) begin
      scratch_d = writedata;
    end
    if (wr_en && (address == ADDR_WIDTH'(ADDR_CONTROL))) begin
      freeze_d = writedata[CTRL_FREEZE];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rvalid_q   <= 1'b0;
      scratch_q  <= '0;
      freeze_q   <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
      scratch_q  <= scratch_d;
      freeze_q   <= freeze_d;
    end
  end

  sysid_uptime_counter u_uptime (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (clear),
    .enable_i    (!freeze_q),
    .capture_i   (capture),
    .count_o     (uptime),
    .hi_shadow_o (hi_shadow)
  );

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;
  assign uptime_frozen = freeze_q;

endmodule

// File: tb/tb_sysid_regfile.sv
// Self-checking bench for sysid_regfile: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_sysid_regfile;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   address;
  logic         read;
  logic         write;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic         readdatavalid;
  logic [127:0] user_info;
  logic         uptime_frozen;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state (updated once per clock edge by step()).
  logic [63:0] m_up;
  logic [31:0] m_hi;
  logic [31:0] m_scratch;
  logic        m_freeze;
  logic        m_valid;
  logic [31:0] m_data;

  always #5 clock = ~clock;

  sysid_regfile dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .user_info     (user_info),
    .uptime_frozen (uptime_frozen)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h0400_0000;
      4'd1:    return 32'd1415959147;
      4'd2:    return 32'h0001_0000;
      4'd3:    return m_scratch;
      4'd4:    return m_up[31:0];
      4'd5:    return m_hi;
      4'd6:    return {30'd0, m_freeze, 1'b0};
      4'd7:    return 32'h0000_0404;
      4'd8:    return user_info[31:0];
      4'd9:    return user_info[63:32];
      4'd10:   return user_info[95:64];
      4'd11:   return user_info[127:96];
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, take the edge, advance the model, then compare.
  task automatic step(input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] wd, input logic rst_n);
    logic clr;
    logic nf;
    read      = rd;
    write     = wr;
    address   = a;
    writedata = wd;
    reset_n   = rst_n;
    @(posedge clock);
    if (!rst_n) begin
      m_valid = 1'b0; m_data = '0; m_scratch = '0;
      m_up = '0; m_hi = '0; m_freeze = 1'b0;
    end else begin
      clr = 1'b0;
      nf  = m_freeze;
      m_valid = rd;
      if (rd) begin
        m_data = ref_read(a);
        if (a == 4'd4) m_hi = m_up[63:32];
      end else if (wr) begin
        if (a == 4'd3) m_scratch = wd;
        if (a == 4'd6) begin
          clr = wd[0];
          nf  = wd[1];
        end
      end
      if (clr)            m_up = '0;
      else if (!m_freeze) m_up = m_up + 64'd1;
      m_freeze = nf;
    end
    #1;
    check("readdatavalid", readdatavalid, m_valid);
    check("readdata", readdata, m_data);
    check("uptime_frozen", uptime_frozen, m_freeze);
    if (rd) $display("[TB] rd addr=%0d rst_n=%0b data=%h valid=%0b", a, rst_n, readdata, readdatavalid);
    else if (wr) $display("[TB] wr addr=%0d data=%h", a, wd);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1);
  endtask

  initial begin
    logic [31:0] lo_first;
    logic        rd, wr, rst;
    logic [3:0]  a;
    logic [31:0] wd;

    reset_n = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    user_info = '0;
    m_up = '0; m_hi = '0; m_scratch = '0; m_freeze = 1'b0; m_valid = 1'b0; m_data = '0;
    @(negedge clock);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    check("reset_readdata", readdata, 32'd0);
    check("reset_valid", readdatavalid, 1'b0);

    // Identity words back-to-back.
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b1); check("sysid", readdata, 32'h0400_0000);
    step(1'b1, 1'b0, 4'd1, 32'd0, 1'b1); check("timestamp", readdata, 32'd1415959147);
    step(1'b1, 1'b0, 4'd2, 32'd0, 1'b1); check("version", readdata, 32'h0001_0000);
    idle(1);
    check("valid_drops", readdatavalid, 1'b0);

    // Scratch and its reset.
    step(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b0, 4'd3, 32'd0, 1'b1); check("scratch_rw", readdata, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 4'd3, 32'd0, 1'b1); check("scratch_reset", readdata, 32'd0);

    // Uptime snapshot across a 32-bit carry.
    force dut.u_uptime.count_q = 64'h0000_0001_FFFF_FFFE;
    release dut.u_uptime.count_q;
    m_up = 64'h0000_0001_FFFF_FFFE;
    idle(1);
    step(1'b1, 1'b0, 4'd4, 32'd0, 1'b1); check("uptime_lo", readdata, 32'hFFFF_FFFF);
    idle(3);
    step(1'b1, 1'b0, 4'd5, 32'd0, 1'b1); check("uptime_hi_snap", readdata, 32'h1);
    step(1'b1, 1'b0, 4'd5, 32'd0, 1'b1); check("uptime_hi_hold", readdata, 32'h1);
    step(1'b1, 1'b0, 4'd4, 32'd0, 1'b1);
    step(1'b1, 1'b0, 4'd5, 32'd0, 1'b1); check("uptime_hi_new", readdata, 32'h2);

    // Freeze, then clear while frozen.
    step(1'b0, 1'b1, 4'd6, 32'd2, 1'b1);
    step(1'b1, 1'b0, 4'd4, 32'd0, 1'b1);
    lo_first = readdata;
    idle(10);
    step(1'b1, 1'b0, 4'd4, 32'd0, 1'b1); check("frozen_lo", readdata, lo_first);
    check("frozen_flag", uptime_frozen, 1'b1);
    step(1'b0, 1'b1, 4'd6, 32'd3, 1'b1);
    step(1'b1, 1'b0, 4'd4, 32'd0, 1'b1); check("clear_lo", readdata, 32'd0);
    step(1'b1, 1'b0, 4'd5, 32'd0, 1'b1); check("clear_hi", readdata, 32'd0);
    step(1'b1, 1'b0, 4'd6, 32'd0, 1'b1); check("control_rd", readdata, 32'h2);
    step(1'b0, 1'b1, 4'd6, 32'd0, 1'b1);

    // User words, info word, unmapped addresses.
    user_info[95:64] = 32'h1234_5678;
    step(1'b1, 1'b0, 4'd10, 32'd0, 1'b1); check("user2", readdata, 32'h1234_5678);
    step(1'b1, 1'b0, 4'd7, 32'd0, 1'b1);  check("info", readdata, 32'h0000_0404);
    step(1'b1, 1'b0, 4'd12, 32'd0, 1'b1); check("unmapped12", readdata, 32'd0);
    step(1'b1, 1'b0, 4'd15, 32'd0, 1'b1); check("unmapped15", readdata, 32'd0);

    // Read wins over a simultaneous write.
    step(1'b0, 1'b1, 4'd3, 32'h0000_A5A5, 1'b1);
    step(1'b1, 1'b1, 4'd3, 32'h0000_1111, 1'b1); check("rw_collide_rd", readdata, 32'h0000_A5A5);
    step(1'b1, 1'b0, 4'd3, 32'd0, 1'b1);         check("rw_collide_keep", readdata, 32'h0000_A5A5);

    // Reset right after a read, and a read during reset.
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0); check("rst_after_rd_valid", readdatavalid, 1'b0);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0); check("rd_in_rst_valid", readdatavalid, 1'b0);
    idle(1);
    check("no_late_valid", readdatavalid, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(0, 2) == 0);
      wr  = ($urandom_range(0, 2) == 0);
      a   = 4'($urandom_range(0, 15));
      wd  = $urandom;
      if (a == 4'd6) wd[0] = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 15) == 0) user_info = {$urandom, $urandom, $urandom, $urandom};
      step(rd, wr, a, wd, !rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
